multicycle_control_32: RTL

Multi-cycle MIPS main controller; successor to the single-cycle opcode decoder. A state machine sequences fetch, decode, execute, memory and writeback over several cycles. It drives the shared-ALU/shared-memory datapath control lines and waits on a memory ready handshake. It sits between the instruction register (opcode/funct) and the multi-cycle datapath.

---
 rtl/multicycle_control_32.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_32.sv
// multicycle_control_32: multi-cycle MIPS main controller sequencing fetch/decode/execute/memory/writeback
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   opcode, funct         instruction fields from the IR (opcode valid from DECODE onward)
//   mem_ready             memory completes the current read/write this cycle
//   pc_write, pc_write_cond, pc_source        PC update control
//   iord, mem_read, mem_write, ir_write       memory/IR control
//   mem_toreg, reg_dst, reg_write             register-file write control
//   alu_src_a, alu_src_b, alu_op              shared ALU control
//   state                 current state encoding (debug)
//   err_illegal_opcode, err_mem_timeout       sticky error flags, cleared only by reset
// Build option: define MC_CTRL_LINK_EN to support jal and jr; otherwise jal is illegal
// and an R-type with funct=001000 executes as an ordinary R-type.
module multicycle_control_32 #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic [1:0] pc_write_cond,
  output logic [1:0] pc_source,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] mem_toreg,
  output logic [1:0] reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [3:0] state,
  output logic       err_illegal_opcode,
  output logic       err_mem_timeout
);
  // ILLEGAL has no visible encoding of its own; it reports as 15 alongside HALT.
  typedef enum logic [4:0] {
    S_IDLE = 5'd0, S_FETCH = 5'd1, S_DECODE = 5'd2, S_MEMADR = 5'd3,
    S_MEMRD = 5'd4, S_MEMWB = 5'd5, S_MEMWR = 5'd6, S_EXEC = 5'd7,
    S_ALUWB = 5'd8, S_BRANCH = 5'd9, S_ADDIEX = 5'd10, S_ADDIWB = 5'd11,
    S_JUMP = 5'd12, S_JAL = 5'd13, S_JR = 5'd14, S_HALT = 5'd15,
    S_ILLEGAL = 5'd16
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MC_CTRL_LINK_EN
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] FN_JR   = 6'b001000;
`endif

  state_t cur, nxt;
  logic [TO_CNT_W-1:0] to_cnt;
  logic waiting, to_hit;

`ifndef MC_CTRL_LINK_EN
  logic unused_funct;
  assign unused_funct = ^funct;
`endif

  assign waiting = (cur == S_FETCH) || (cur == S_MEMRD) || (cur == S_MEMWR);
  // Ready on the last allowed cycle still wins over the timeout.
  assign to_hit = (MEM_TIMEOUT > 0) && waiting && !mem_ready && (to_cnt == TO_CNT_W'(MEM_TIMEOUT - 1));
  assign state = (cur == S_ILLEGAL) ? 4'd15 : cur[3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur                <= S_IDLE;
      to_cnt             <= '0;
      err_illegal_opcode <= 1'b0;
      err_mem_timeout    <= 1'b0;
    end else begin
      cur                <= nxt;
      // Staying in a wait state means no ready this cycle; any state change restarts the count.
      to_cnt             <= (waiting && nxt == cur) ? to_cnt + 1'b1 : '0;
      err_illegal_opcode <= err_illegal_opcode | (cur == S_ILLEGAL);
      err_mem_timeout    <= err_mem_timeout | to_hit;
    end
  end

  always_comb begin
    nxt = cur;
    case (cur)
      S_IDLE:   nxt = S_FETCH;
      S_FETCH:  nxt = mem_ready ? S_DECODE : to_hit ? S_HALT : S_FETCH;
      S_DECODE:
        case (opcode)
          OP_R:           nxt = S_EXEC;
          OP_LW, OP_SW:   nxt = S_MEMADR;
          OP_BEQ, OP_BNE: nxt = S_BRANCH;
          OP_ADDI:        nxt = S_ADDIEX;
          OP_J:           nxt = S_JUMP;
`ifdef MC_CTRL_LINK_EN
          OP_JAL:         nxt = S_JAL;
`endif
          default:        nxt = S_ILLEGAL;
        endcase
      S_MEMADR: nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  nxt = mem_ready ? S_MEMWB : to_hit ? S_HALT : S_MEMRD;
      S_MEMWR:  nxt = mem_ready ? S_FETCH : to_hit ? S_HALT : S_MEMWR;
`ifdef MC_CTRL_LINK_EN
      S_EXEC:   nxt = (funct == FN_JR) ? S_JR : S_ALUWB;
`else
      S_EXEC:   nxt = S_ALUWB;
`endif
      S_ADDIEX: nxt = S_ADDIWB;
      S_ILLEGAL, S_HALT: nxt = S_HALT;
      default:  nxt = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 2'b00;
    pc_source     = 2'b00;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_toreg     = 2'b11;
    reg_dst       = 2'b11;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b11;
    case (cur)
      S_IDLE, S_ILLEGAL, S_HALT: begin
        mem_toreg = 2'b00;
        reg_dst   = 2'b00;
        alu_op    = 2'b00;
      end
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = 2'b00;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = 2'b00;
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 2'b00;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write = 1'b1;
        reg_dst   = 2'b00;
        mem_toreg = 2'b01;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 2'b01;
        mem_toreg = 2'b00;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_source     = 2'b01;
        pc_write_cond = (opcode == OP_BNE) ? 2'b11 : 2'b10;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        reg_dst   = 2'b00;
        mem_toreg = 2'b00;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      S_JAL: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        reg_write = 1'b1;
        reg_dst   = 2'b10;
        mem_toreg = 2'b10;
      end
      S_JR: begin
        pc_write  = 1'b1;
        pc_source = 2'b11;
      end
      default: pc_write = 1'b0;
    endcase
  end
endmodule
